// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter with a per-register pending scoreboard.
// Two writeback requesters (0 = ALU, 1 = load) share one registered write
// stage; the issue stage reserves destinations and reads back hazard flags.

// One scoreboard bit: a new producer wins over a same-edge retire.
module reg_sb_cell (
  input  logic clk,
  input  logic reset_enable,
  input  logic set,
  input  logic clr,
  output logic pend,
  output logic rise,
  output logic fall
);
  logic nxt;

  assign nxt  = set | (pend & ~clr);
  assign rise = nxt & ~pend;
  assign fall = ~nxt & pend;

  // Pending bit, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset_enable) pend <= 1'b0;
    else              pend <= nxt;
  end
endmodule

module reg_write_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_INDEX     = 4,
  parameter int REG_FILE_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_enable,
  input  logic                 req0_valid,
  input  logic [REG_INDEX-1:0] req0_num,
  input  logic [WORD_SIZE-1:0] req0_val,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [REG_INDEX-1:0] req1_num,
  input  logic [WORD_SIZE-1:0] req1_val,
  output logic                 req1_ready,
  input  logic                 reserve_enable,
  input  logic [REG_INDEX-1:0] reserve_num,
  output logic                 reserve_conflict,
  input  logic [REG_INDEX-1:0] chk_num1,
  input  logic [REG_INDEX-1:0] chk_num2,
  input  logic [REG_INDEX-1:0] chk_num3,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic                 hazard3,
  output logic [REG_INDEX:0]   pending_count,
  output logic [REG_INDEX-1:0] set_num,
  output logic [WORD_SIZE-1:0] set_val,
  output logic                 set_enable
);

  logic                     last_grant;
  logic [REG_FILE_SIZE-1:0] pending, rise, fall;
  logic                     accept;

  // Round-robin on contention: the requester not granted last wins.
  assign req0_ready = !reset_enable && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = !reset_enable && req1_valid && (!req0_valid || !last_grant);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Output stage; last_grant resets to 1 so req0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset_enable) begin
      set_enable <= 1'b0;
      set_num    <= '0;
      set_val    <= '0;
      last_grant <= 1'b1;
    end else begin
      set_enable <= accept;
      if (req0_ready) begin
        set_num    <= req0_num;
        set_val    <= req0_val;
        last_grant <= 1'b0;
      end else if (req1_ready) begin
        set_num    <= req1_num;
        set_val    <= req1_val;
        last_grant <= 1'b1;
      end
    end
  end

  // Scoreboard: the retire clears at the same edge the register file
  // captures the value, so hazards drop exactly when the data is readable.
  for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_sb
    reg_sb_cell u_cell (
      .clk          (clk),
      .reset_enable (reset_enable),
      .set          (reserve_enable && (reserve_num == REG_INDEX'(g))),
      .clr          (set_enable && (set_num == REG_INDEX'(g))),
      .pend         (pending[g]),
      .rise         (rise[g]),
      .fall         (fall[g])
    );
  end

  assign reserve_conflict = reserve_enable && pending[reserve_num];
  assign hazard1 = pending[chk_num1];
  assign hazard2 = pending[chk_num2];
  assign hazard3 = pending[chk_num3];

  // Population count tracked incrementally from bit transitions.
  always_ff @(posedge clk) begin
    if (reset_enable) pending_count <= '0;
    else pending_count <= pending_count + (REG_INDEX+1)'($countones(rise))
                                        - (REG_INDEX+1)'($countones(fall));
  end

endmodule
